// File: rtl/trig_debounce.sv
`default_nettype none
// ============================================================================
// Module      : trig_debounce
// Description : Synchronise, debounce and publish a raw level as trig, with
//               one-cycle rise/fall strobes. Define DEBOUNCE_GLITCH_CNT_EN to
//               add a saturating count of aborted qualifications.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    output logic       trig,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    localparam logic [1:0] c_idle_low  = 2'd0;
    localparam logic [1:0] c_qual_high = 2'd1;
    localparam logic [1:0] c_idle_high = 2'd2;
    localparam logic [1:0] c_qual_low  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   trig_q, trig_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s      = sync_q[SYNC_STAGES-1];

    // State register: synchroniser, FSM, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= c_idle_low;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic; a disabled block parks in the idle state matching trig.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = trig_q ? c_idle_high : c_idle_low;
            cnt_d   = '0;
        end else begin
            case (state_q)
                c_idle_low: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = c_idle_high;
                        end else begin
                            state_d = c_qual_high;
                            cnt_d   = c_cnt_one;
                        end
                    end
                end
                c_qual_high: begin
                    if (!s) begin
                        state_d = c_idle_low;
                        cnt_d   = '0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_d = c_idle_high;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
                c_idle_high: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = c_idle_low;
                        end else begin
                            state_d = c_qual_low;
                            cnt_d   = c_cnt_one;
                        end
                    end
                end
                default: begin
                    if (s) begin
                        state_d = c_idle_high;
                        cnt_d   = '0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_d = c_idle_low;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
            endcase
        end
    end

    // Output logic: trig follows the level the next state represents.
    always_comb begin
        trig_d = (state_d == c_idle_high) || (state_d == c_qual_low);
        rise_d = trig_d & ~trig_q;
        fall_d = ~trig_d & trig_q;
        busy   = (state_q == c_qual_high) || (state_q == c_qual_low);
    end

    assign trig = trig_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;
    logic       abort;

    // Only a reverting input counts; disabling the block is not a glitch.
    assign abort = en && (((state_q == c_qual_high) && !s) ||
                          ((state_q == c_qual_low)  &&  s));

    always_comb begin
        glitch_d = glitch_q;
        if (abort && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trig_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_debounce
// Description : Directed bench for trig_debounce, default and fast configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic din_a, din_b;
    logic trig_a, rise_a, fall_a, busy_a;
    logic trig_b, rise_b, fall_b, busy_b;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_a, glitch_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trig_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CNT_WIDTH(5)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (din_a),
        .trig  (trig_a),
        .rise  (rise_a),
        .fall  (fall_a),
        .busy  (busy_a)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_a)
`endif
    );

    trig_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(5)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .din   (din_b),
        .trig  (trig_b),
        .rise  (rise_b),
        .fall  (fall_b),
        .busy  (busy_b)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n edges; trig goes high at up_e and low at dn_e (0 = never).
    task automatic watch(input string nm, input bit sel, input int n, input int up_e,
                         input int dn_e, input bit lvl0, input bit chk_busy,
                         input int b_lo, input int b_hi);
        bit lvl;
        lvl = lvl0;
        for (int e = 1; e <= n; e++) begin
            step();
            if (e == up_e) lvl = 1'b1;
            if (e == dn_e) lvl = 1'b0;
            check($sformatf("%s trig e%0d", nm, e), sel ? trig_b : trig_a, lvl);
            check($sformatf("%s rise e%0d", nm, e), sel ? rise_b : rise_a, (e == up_e));
            check($sformatf("%s fall e%0d", nm, e), sel ? fall_b : fall_a, (e == dn_e));
            if (chk_busy)
                check($sformatf("%s busy e%0d", nm, e), sel ? busy_b : busy_a,
                      (e >= b_lo && e <= b_hi));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        din_a = 1'b0;
        din_b = 1'b0;
        #2;
        check("rst trig", trig_a, 0);
        check("rst rise", rise_a, 0);
        check("rst fall", fall_a, 0);
        check("rst busy", busy_a, 0);
        check("rst trig_b", trig_b, 0);
        repeat (3) step();
        rst_n = 1'b1;
        watch("idle", 0, 5, 0, 0, 0, 1, 1, 0);

        // Clean rising step
        din_a = 1'b1;
        watch("step_up", 0, 40, 18, 0, 0, 1, 3, 17);

        // Asynchronous reset while trig is high
        rst_n = 1'b0;
        #2;
        check("async trig", trig_a, 0);
        check("async rise", rise_a, 0);
        check("async fall", fall_a, 0);
        check("async busy", busy_a, 0);
        repeat (3) step();
        rst_n = 1'b1;
        watch("rst_requal", 0, 25, 18, 0, 0, 1, 3, 17);

        // Clean falling step
        din_a = 1'b0;
        watch("step_dn", 0, 25, 0, 18, 1, 1, 3, 17);

        // 15 sampled cycles: rejected
        din_a = 1'b1;
        watch("b15_hi", 0, 15, 0, 0, 0, 0, 0, 0);
        din_a = 1'b0;
        watch("b15_lo", 0, 10, 0, 0, 0, 1, 1, 2);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch b15", glitch_a, 1);
`endif

        // 16 sampled cycles: accepted, then falls 18 edges after 1->0
        din_a = 1'b1;
        watch("b16_hi", 0, 16, 0, 0, 0, 0, 0, 0);
        din_a = 1'b0;
        watch("b16_lo", 0, 25, 2, 18, 0, 0, 0, 0);

        // Bounce: high 5, low 3, high held
        din_a = 1'b1;
        watch("bnc_h5", 0, 5, 0, 0, 0, 0, 0, 0);
        din_a = 1'b0;
        watch("bnc_l3", 0, 3, 0, 0, 0, 0, 0, 0);
        din_a = 1'b1;
        watch("bnc_hold", 0, 25, 18, 0, 0, 0, 0, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch bnc", glitch_a, 2);
`endif

        // Return low, then enable gating during qualification
        din_a = 1'b0;
        watch("en_prep", 0, 25, 0, 18, 1, 0, 0, 0);
        din_a = 1'b1;
        watch("en_pre", 0, 9, 0, 0, 0, 1, 3, 9);
        en = 1'b0;
        watch("en_off", 0, 5, 0, 0, 0, 1, 1, 0);
        en = 1'b1;
        watch("en_on", 0, 25, 16, 0, 0, 1, 1, 15);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch en", glitch_a, 2);
`endif

        // Fast config: SYNC_STAGES=3, DEBOUNCE_CYCLES=1
        din_b = 1'b1;
        watch("fast_up", 1, 8, 4, 0, 0, 1, 1, 0);
        din_b = 1'b0;
        watch("fast_dn", 1, 8, 0, 4, 1, 1, 1, 0);
        din_b = 1'b1;
        watch("fast_p1", 1, 1, 0, 0, 0, 0, 0, 0);
        din_b = 1'b0;
        watch("fast_p2", 1, 8, 3, 4, 0, 1, 1, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch fast", glitch_b, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trig_debounce.md
Name: trig_debounce

Overview:
- Conditions a raw asynchronous level input (button, 1PPS line, RTC oscillator-derived strobe) into a clean, clock-synchronous level `trig`.
- `trig` feeds the edge-counting stage directly downstream.
- Three stages in sequence: synchronise, then qualify (debounce) with a stable-count filter, then publish the level plus one-cycle rise/fall strobes.
- Purpose: the downstream counter sees exactly one low-to-high transition per physical event.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on din; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive sampled cycles of a new level required before trig changes; legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 5: width of the qualification counter.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  qualification enable.
- din  input  1  raw asynchronous input level.
- trig  output  1  debounced level (drives the downstream counter's trig).
- rise  output  1  one-cycle pulse coincident with trig going 0->1.
- fall  output  1  one-cycle pulse coincident with trig going 1->0.
- busy  output  1  high while a level change is being qualified (QUAL_HIGH or QUAL_LOW).

Behaviour:
- Reset (rst_n=0, takes effect asynchronously):
  - all sync flops=0, trig=0, rise=0, fall=0, busy=0, cnt=0, state=IDLE_LOW.
  - Release is used synchronously; the first active edge is the first clk rising edge with rst_n=1.
- Synchroniser: din passes through SYNC_STAGES flops; the last flop is s. The chain runs regardless of en.
- FSM states:
  - IDLE_LOW: trig=0.
  - QUAL_HIGH: trig=0, busy=1.
  - IDLE_HIGH: trig=1.
  - QUAL_LOW: trig=1, busy=1.
- cnt counts consecutive edges at which s != trig.
- IDLE_LOW transitions:
  - s=1 and DEBOUNCE_CYCLES=1: go to IDLE_HIGH.
  - s=1 otherwise: go to QUAL_HIGH with cnt=1.
- QUAL_HIGH transitions:
  - s=0: abort to IDLE_LOW, cnt=0.
  - s=1 and cnt=DEBOUNCE_CYCLES-1: go to IDLE_HIGH, cnt=0.
  - otherwise: cnt+1.
- IDLE_HIGH and QUAL_LOW: mirror images of the above with levels inverted.
- Outputs are registered:
  - trig, rise and fall update on the edge where the FSM enters IDLE_HIGH or IDLE_LOW from a qualifying or idle state.
  - rise/fall are high for exactly that one cycle.
  - rise and fall are never high together.
- Latency: count as edge 1 the first edge at which sync flop 1 captures the new din level. trig changes at edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 18).
- Minimum accepted pulse: a din level held for DEBOUNCE_CYCLES sampled cycles is accepted. One held for DEBOUNCE_CYCLES-1 is rejected, and trig is unchanged.
- en=0:
  - FSM returns to the idle state matching the current trig, cnt=0, rise=fall=0, busy=0; trig holds.
  - Re-enable restarts qualification from cnt=0.
- cnt never wraps; the parameter range guarantees the terminal value is reachable.
- Simultaneous events:
  - Reset has priority over everything.
  - en=0 has priority over qualification completion on the same edge; trig does not change.
- Reset asserted mid-qualification: immediate return to reset values. The input must re-qualify from scratch after release.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN
- Defined:
  - Adds output port glitch_count, 8 bits, reset 0.
  - Increments by 1 on every aborted qualification (QUAL_HIGH->IDLE_LOW or QUAL_LOW->IDLE_HIGH caused by s reverting).
  - Saturates at 255.
  - Not incremented by en=0 aborts.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold din=1 for 30 cycles, then assert rst_n=0 between clock edges -> trig, rise, fall, busy drop to 0 immediately, before the next edge. After release with din=1, trig rises at edge 18.
- Clean step with defaults: din 0->1 held 40 cycles -> trig=1 from edge 18, rise=1 only during that cycle, busy=1 for edges 3..17, fall=0 throughout.
- Boundary: din high for exactly 15 sampled cycles then low -> trig stays 0. Repeat with exactly 16 cycles -> trig rises, then falls 18 edges after the 1->0 change with a single fall pulse.
- Bounce: din pattern high 5, low 3, high held -> one rise pulse only, 18 edges after the final 0->1. With DEBOUNCE_GLITCH_CNT_EN, glitch_count=1.
- Enable gating: din 0->1, drop en to 0 at edge 10 for 5 cycles, then restore -> no rise during or at edge 18. trig rises 16 edges after en returns high. glitch_count unchanged.
- Parameter corner DEBOUNCE_CYCLES=1, SYNC_STAGES=3: din 0->1 -> trig=1 at edge 4. A single-cycle din pulse -> trig high for exactly one cycle, with a rise pulse followed by a fall pulse.
